// File: rtl/temp_averager_pkg.sv
// Shared definitions for the temperature averager: state encoding,
// ADC word width and the code-per-degree scale of the sensor path.
package temp_averager_pkg;

    localparam int ADC_W         = 12;
    localparam int TEMP_SCALE    = 68;
    localparam int LIMIT_CELSIUS = 40;
    localparam int DEFAULT_LIMIT = LIMIT_CELSIUS * TEMP_SCALE;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_UPDATE = 2'd2
    } state_e;

endpackage

// File: rtl/temp_averager_if.sv
// Sample stream in, averaged temperature and status out.
// master = material system / ADC side, slave = averager.
interface temp_averager_if;
    import temp_averager_pkg::*;

    logic             enable;
    logic             adcValid;
    logic [ADC_W-1:0] adcData;
    logic [ADC_W-1:0] digitalTemp;
    logic             ready;
    logic             timeoutErr;
    logic             overTemp;

    modport master (
        output enable, adcValid, adcData,
        input  digitalTemp, ready, timeoutErr, overTemp
    );

    modport slave (
        input  enable, adcValid, adcData,
        output digitalTemp, ready, timeoutErr, overTemp
    );

endinterface

// File: rtl/temp_averager_stall_timer.sv
// Counts cycles without a sample; tc fires on the cycle whose edge would
// bring the count to TIMEOUT, and the counter restarts from zero there.
module stall_timer
    import temp_averager_pkg::*;
#(
    parameter int TIMEOUT = 50
) (
    input  logic ACLK,
    input  logic ARESETN,
    input  logic clear,
    input  logic cnt_en,
    output logic tc
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q, count_d;

    assign tc = cnt_en && !clear && (count_q == CW'(TIMEOUT - 1));

    always_comb begin
        count_d = count_q;
        if (clear || tc) begin
            count_d = '0;
        end else if (cnt_en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/temp_averager.sv
// Averages blocks of 2^NUM_LOG2 ADC temperature samples, flags over-temperature
// and reports a sticky error when the sample stream stalls.
module temp_averager
    import temp_averager_pkg::*;
#(
    parameter int NUM_LOG2   = 3,
    parameter int TIMEOUT    = 50,
    parameter int TEMP_LIMIT = DEFAULT_LIMIT
) (
    input  logic            ACLK,
    input  logic            ARESETN,
    temp_averager_if.slave  bus
);

    localparam int                 ACC_W      = ADC_W + NUM_LOG2;
    localparam logic [ADC_W:0]     LIMIT_CODE = (ADC_W + 1)'(TEMP_LIMIT);

    state_e                state_q, state_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [NUM_LOG2-1:0]   cnt_q, cnt_d;
    logic [ADC_W-1:0]      temp_q, temp_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;
    logic                  over_q, over_d;

    logic                  timer_clear;
    logic                  timer_en;
    logic                  timer_tc;
    logic [ACC_W-1:0]      acc_sum;
    logic [ADC_W-1:0]      avg;

    assign acc_sum = acc_q + ACC_W'(bus.adcData);
    assign avg     = ADC_W'(acc_q >> NUM_LOG2);

    // Outside ACCUM the timer is held clear, so every entry to ACCUM starts at zero.
    assign timer_clear = (state_q != ST_ACCUM) || bus.adcValid;
    assign timer_en    = (state_q == ST_ACCUM) && bus.enable;

    stall_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_stall_timer (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .clear   (timer_clear),
        .cnt_en  (timer_en),
        .tc      (timer_tc)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        temp_d  = temp_q;
        ready_d = ready_q;
        err_d   = err_q;
        over_d  = over_q;

        case (state_q)
            ST_IDLE: begin
                acc_d = '0;
                cnt_d = '0;
                if (bus.enable) begin
                    state_d = ST_ACCUM;
                end
            end

            ST_ACCUM: begin
                // Dropping enable outranks a coincident sample and any timeout.
                if (!bus.enable) begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else if (bus.adcValid) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_d = ST_UPDATE;
                    end
                end else if (timer_tc) begin
                    err_d   = 1'b1;
                    ready_d = 1'b0;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end

            ST_UPDATE: begin
                temp_d  = avg;
                ready_d = 1'b1;
                err_d   = 1'b0;
                over_d  = ({1'b0, avg} >= LIMIT_CODE);
                acc_d   = '0;
                cnt_d   = '0;
                state_d = bus.enable ? ST_ACCUM : ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                acc_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            temp_q  <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            temp_q  <= temp_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            over_q  <= over_d;
        end
    end

    assign bus.digitalTemp = temp_q;
    assign bus.ready       = ready_q;
    assign bus.timeoutErr  = err_q;
    assign bus.overTemp    = over_q;

endmodule

// File: tb/tb_temp_averager.sv
// Self-checking bench for temp_averager: vector table, directed corner
// sequences and a randomized run against a block-average reference model.
module tb_temp_averager;
    import temp_averager_pkg::*;

    localparam int TIMEOUT = 50;
    localparam int LIMIT   = 2720;

    typedef struct packed {
        logic [7:0][11:0] s;
        logic [11:0]      exp_t;
        logic             exp_o;
    } vec_t;

    logic ACLK    = 1'b0;
    logic ARESETN = 1'b1;

    temp_averager_if bus();

    temp_averager #(
        .NUM_LOG2   (3),
        .TIMEOUT    (TIMEOUT),
        .TEMP_LIMIT (LIMIT)
    ) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .bus     (bus)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;
    int prev_t = 0;
    int prev_o = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input int t, input int r, input int e, input int o);
        check({name, ".digitalTemp"}, 32'(bus.digitalTemp), 32'(t));
        check({name, ".ready"},       32'(bus.ready),       32'(r));
        check({name, ".timeoutErr"},  32'(bus.timeoutErr),  32'(e));
        check({name, ".overTemp"},    32'(bus.overTemp),    32'(o));
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic send(input logic [11:0] d);
        bus.adcValid = 1'b1;
        bus.adcData  = d;
        tick();
        bus.adcValid = 1'b0;
    endtask

    vec_t vecs[7];

    initial begin
        int q[$];
        int results;
        int iters;
        int d;
        int sum;
        int exp_t;

        bus.enable   = 1'b0;
        bus.adcValid = 1'b0;
        bus.adcData  = '0;

        vecs[0] = '{s: {8{12'd1700}},                   exp_t: 12'd1700, exp_o: 1'b0};
        vecs[1] = '{s: {{4{12'd1707}}, {4{12'd1700}}},  exp_t: 12'd1703, exp_o: 1'b0};
        vecs[2] = '{s: {8{12'd4095}},                   exp_t: 12'd4095, exp_o: 1'b1};
        vecs[3] = '{s: {8{12'd2719}},                   exp_t: 12'd2719, exp_o: 1'b0};
        vecs[4] = '{s: {8{12'd2720}},                   exp_t: 12'd2720, exp_o: 1'b1};
        vecs[5] = '{s: {{7{12'd0}}, 12'd7},             exp_t: 12'd0,    exp_o: 1'b0};
        vecs[6] = '{s: {12'd2726, {7{12'd2719}}},       exp_t: 12'd2719, exp_o: 1'b0};

        // Asynchronous reset assertion, checked away from any clock edge
        #2 ARESETN = 1'b0;
        #1;
        check_outs("reset", 0, 0, 0, 0);
        $display("reset: temp=%0d ready=%0d", bus.digitalTemp, bus.ready);
        tick();
        tick();
        ARESETN = 1'b1;
        tick();
        check_outs("post_reset", 0, 0, 0, 0);

        bus.enable = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < 8; j++) begin
                send(vecs[i].s[j]);
            end
            check($sformatf("vec%0d.latency", i), 32'(bus.digitalTemp), 32'(prev_t));
            tick();
            check_outs($sformatf("vec%0d", i), int'(vecs[i].exp_t), 1, 0, int'(vecs[i].exp_o));
            $display("vec %0d: temp=%0d over=%0d expected %0d/%0d", i,
                     bus.digitalTemp, bus.overTemp, vecs[i].exp_t, vecs[i].exp_o);
            prev_t = int'(vecs[i].exp_t);
            prev_o = int'(vecs[i].exp_o);
        end

        // Stall: three samples then 50 empty cycles
        repeat (3) send(12'd3000);
        repeat (TIMEOUT - 1) tick();
        check_outs("timeout_minus1", prev_t, 1, 0, prev_o);
        tick();
        check_outs("timeout", prev_t, 0, 1, prev_o);
        $display("timeout: err=%0d ready=%0d temp=%0d", bus.timeoutErr, bus.ready, bus.digitalTemp);

        // Sample landing on the would-be timeout cycle suppresses it
        repeat (TIMEOUT - 1) tick();
        send(12'd1000);
        repeat (TIMEOUT - 1) tick();
        check_outs("valid_wins", prev_t, 0, 1, prev_o);
        repeat (7) send(12'd1000);
        tick();
        check_outs("recover", 1000, 1, 0, 0);
        $display("recover: temp=%0d err=%0d ready=%0d", bus.digitalTemp, bus.timeoutErr, bus.ready);
        prev_t = 1000;
        prev_o = 0;

        // Enable drops together with the fifth sample
        repeat (4) send(12'd2000);
        bus.enable   = 1'b0;
        bus.adcValid = 1'b1;
        bus.adcData  = 12'd2000;
        tick();
        bus.adcValid = 1'b0;
        tick();
        check_outs("enable_low", 1000, 1, 0, 0);
        bus.enable = 1'b1;
        tick();
        for (int j = 0; j < 8; j++) begin
            send(12'd1000);
            check($sformatf("discard.s%0d", j), 32'(bus.digitalTemp), 32'd1000);
        end
        tick();
        check_outs("discard", 1000, 1, 0, 0);
        $display("discard: temp=%0d ready=%0d", bus.digitalTemp, bus.ready);

        // Reset in the middle of a block
        repeat (4) send(12'd3000);
        #2 ARESETN = 1'b0;
        #1;
        check_outs("mid_reset", 0, 0, 0, 0);
        tick();
        ARESETN = 1'b1;
        tick();
        repeat (7) send(12'd3000);
        tick();
        check_outs("after_reset7", 0, 0, 0, 0);
        send(12'd3000);
        tick();
        check_outs("after_reset8", 3000, 1, 0, 1);
        $display("after reset: temp=%0d ready=%0d over=%0d", bus.digitalTemp, bus.ready, bus.overTemp);
        prev_t = 3000;

        // Randomized blocks checked against plain arithmetic averages
        results = 0;
        iters   = 0;
        while (results < 30 && iters < 2000) begin
            iters++;
            if ($urandom_range(0, 29) == 0) begin
                bus.enable = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
                bus.enable = 1'b1;
                tick();
                q.delete();
            end
            d = int'($urandom_range(0, 4095));
            send(12'(d));
            q.push_back(d);
            if (q.size() == 8) begin
                sum = 0;
                foreach (q[k]) sum += q[k];
                exp_t = sum / 8;
                check($sformatf("rand%0d.latency", results), 32'(bus.digitalTemp), 32'(prev_t));
                tick();
                check_outs($sformatf("rand%0d", results), exp_t, 1, 0, (exp_t >= LIMIT) ? 1 : 0);
                $display("rand %0d: temp=%0d expected %0d", results, bus.digitalTemp, exp_t);
                prev_t = exp_t;
                q.delete();
                results++;
            end else begin
                repeat ($urandom_range(0, 15)) tick();
            end
        end
        check("rand.result_count", 32'(results), 32'd30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/temp_averager.md
TEMP_AVERAGER -- requirements
Module: temp_averager

Interface
REQ-001 Parameter NUM_LOG2, default 3, log2 of the number of samples averaged per result (8 samples).
REQ-002 Parameter TIMEOUT, default 50, ACLK cycles allowed between adcValid pulses while accumulating.
REQ-003 Parameter TEMP_LIMIT, default 2720 (40 C at 68 codes/C), overTemp threshold in ADC codes.
REQ-004 ACLK  input  1  system clock; all state changes on its rising edge.
REQ-005 ARESETN  input  1  reset, asynchronous assert, active-low.
REQ-006 enable  input  1  sampling request from the material system; high = accumulate.
REQ-007 adcValid  input  1  one-cycle pulse, adcData holds a new conversion.
REQ-008 adcData  input  12  raw XADC temperature code.
REQ-009 digitalTemp  output  12  registered averaged temperature code, fed to material system.
REQ-010 ready  output  1  high while digitalTemp holds a valid average.
REQ-011 timeoutErr  output  1  sticky flag, sample stream stalled.
REQ-012 overTemp  output  1  registered, digitalTemp >= TEMP_LIMIT.

Function
REQ-013 FSM states SHALL be IDLE, ACCUM, UPDATE.
REQ-014 IDLE: accumulator and sample count held at 0; adcValid ignored; enable=1 -> ACCUM next cycle.
REQ-015 ACCUM: each adcValid adds adcData to a (12+NUM_LOG2)-bit accumulator and increments the sample count; no overflow possible.
REQ-016 ACCUM: capture of sample 2^NUM_LOG2 SHALL move to UPDATE on the same edge.
REQ-017 UPDATE: digitalTemp <= accumulator >> NUM_LOG2 (truncating), ready <= 1, timeoutErr <= 0, overTemp <= (new value >= TEMP_LIMIT); accumulator/count cleared; next state ACCUM if enable=1, else IDLE.
REQ-018 Latency: digitalTemp/ready update on the edge following the edge that captured the last sample (one cycle).
REQ-019 digitalTemp and overTemp SHALL change only in UPDATE or reset; ready stays high across subsequent accumulations.
REQ-020 enable=0 in ACCUM: discard partial sum, go IDLE; digitalTemp, ready, overTemp retained.
REQ-021 enable falling on the same cycle as adcValid: enable wins, sample discarded.
REQ-022 Timeout counter resets on entry to ACCUM and on each adcValid; increments otherwise in ACCUM.
REQ-023 Counter reaching TIMEOUT: timeoutErr <= 1, ready <= 0, partial sum discarded, counter restarted, stay in ACCUM; digitalTemp retained.
REQ-024 Timeout and adcValid on the same cycle: adcValid wins, no timeout.
REQ-025 Timeout counter inactive in IDLE and UPDATE.

Reset
REQ-026 ARESETN=0 SHALL immediately force state IDLE, accumulator/counts 0, digitalTemp 0, ready 0, timeoutErr 0, overTemp 0.
REQ-027 Reset mid-ACCUM SHALL discard the partial sum; first result after release requires a full 2^NUM_LOG2 fresh samples.

Structure
REQ-028 Shared package SHALL hold the FSM state encoding and TEMP_SCALE = 68 codes/C.
REQ-029 Timeout counter SHALL be one sub-module, stall_timer (clear, count enable, terminal-count output); everything else flat.

Verification
REQ-030 Reset, enable=1, eight adcValid pulses of 1700 -> digitalTemp=1700, ready=1, overTemp=0 one cycle after the 8th pulse.
REQ-031 Four samples 1700 then four 1707 -> digitalTemp=1703 (truncation of 1703.5).
REQ-032 Eight samples of 4095 -> digitalTemp=4095, overTemp=1; then eight of 2719 -> overTemp=0.
REQ-033 After a valid result, three samples then 50 idle cycles -> timeoutErr=1, ready=0, digitalTemp unchanged; next eight samples -> timeoutErr=0, ready=1.
REQ-034 Five samples of 2000, enable=0 for 2 cycles, enable=1, eight samples of 1000 -> single update to 1000, no 2000-weighted result.
REQ-035 ARESETN pulsed low after four samples -> all outputs 0 asynchronously; eight further samples required for ready=1.
